sd_spi_engine: RTL

- SPI bit engine directly downstream of the SD card mode controller.
- Generates SCLK at one of three speeds and serialises one byte per 8 clocks onto MOSI. The byte comes from the command frame generator, the data-out FIFO, or an 0xFF filler, selected by SPI_select.
- Deserialises MISO into rx_byte.
- Returns the controller's pacing strobes: shift_enable, byte_transf, edge_detect.

---
 rtl/sd_spi_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sd_spi_engine.sv
// SPI bit engine for the SD card controller: SCLK divider, MSB-first byte
// serialiser with pending-byte staging, and MISO deserialiser with pacing strobes.
module sd_spi_engine #(
    parameter int unsigned HALF_SLOW = 32,
    parameter int unsigned HALF_MED  = 4,
    parameter int unsigned HALF_FAST = 1,
    parameter logic [7:0]  CRC_CMD0  = 8'h95
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [1:0]  speed,
    input  logic [1:0]  SPI_select,
    input  logic        load_enable,
    input  logic [5:0]  cmd_out,
    input  logic [3:0]  count_out,
    input  logic [31:0] addr_i,
    input  logic [7:0]  tx_data,
    input  logic        clear_byte,
    input  logic        sd_miso,
    output logic        sd_sclk,
    output logic        sd_mosi,
    output logic        shift_enable,
    output logic        byte_transf,
    output logic        edge_detect,
    output logic [7:0]  rx_byte
);

    logic [15:0] half_cnt;
    logic [15:0] half_lim_q;
    logic [15:0] lim_sel;
    logic [15:0] lim_now;
    logic        toggle;
    logic        rise;
    logic        fall;

    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_next;
    logic        miso_prev;

    logic [7:0]  tx_shift;
    logic [7:0]  tx_next;
    logic [7:0]  pending_byte;
    logic        pending_valid;
    logic        at_boundary;

    logic [7:0]  frame_byte;
    logic [7:0]  sel_byte;
    logic        cmd_zero;

    always_comb begin
        case (speed)
            2'b00:   lim_sel = 16'(HALF_SLOW - 1);
            2'b01:   lim_sel = 16'(HALF_MED - 1);
            default: lim_sel = 16'(HALF_FAST - 1);
        endcase
    end

    // The limit is latched at the first cycle of each half-period, so a speed
    // change never truncates the half already in progress.
    assign lim_now = (half_cnt == '0) ? lim_sel : half_lim_q;
    assign toggle  = (half_cnt == lim_now);
    assign rise    = toggle && !sd_sclk;
    assign fall    = toggle && sd_sclk;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            half_cnt   <= '0;
            half_lim_q <= 16'(HALF_SLOW - 1);
            sd_sclk    <= 1'b0;
        end else begin
            if (half_cnt == '0)
                half_lim_q <= lim_sel;
            if (toggle) begin
                half_cnt <= '0;
                sd_sclk  <= ~sd_sclk;
            end else begin
                half_cnt <= half_cnt + 16'd1;
            end
        end
    end

    assign cmd_zero = (cmd_out == '0);

    always_comb begin
        frame_byte = 8'hFF;
        if (cmd_out == 6'b111111) begin
            frame_byte = 8'hFE;
        end else begin
            case (count_out)
                4'd0:    frame_byte = {2'b01, cmd_out};
                4'd1:    frame_byte = cmd_zero ? 8'h00 : addr_i[31:24];
                4'd2:    frame_byte = cmd_zero ? 8'h00 : addr_i[23:16];
                4'd3:    frame_byte = cmd_zero ? 8'h00 : addr_i[15:8];
                4'd4:    frame_byte = cmd_zero ? 8'h00 : addr_i[7:0];
                4'd5:    frame_byte = cmd_zero ? CRC_CMD0 : 8'hFF;
                default: frame_byte = 8'hFF;
            endcase
        end
    end

    always_comb begin
        case (SPI_select)
            2'b01:   sel_byte = tx_data;
            2'b10:   sel_byte = frame_byte;
            default: sel_byte = 8'hFF;
        endcase
    end

    assign rx_next = {rx_shift[6:0], sd_miso};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_shift     <= 8'hFF;
            rx_byte      <= 8'hFF;
            bit_cnt      <= '0;
            miso_prev    <= 1'b1;
            shift_enable <= 1'b0;
            byte_transf  <= 1'b0;
            edge_detect  <= 1'b0;
        end else begin
            shift_enable <= rise;
            edge_detect  <= rise && !sd_miso && miso_prev;
            byte_transf  <= 1'b0;
            if (rise)
                miso_prev <= sd_miso;
            // A clear coincident with a rising edge drops that sample and any byte completion.
            if (clear_byte) begin
                bit_cnt  <= '0;
                rx_shift <= 8'hFF;
            end else if (rise) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte     <= rx_next;
                    byte_transf <= 1'b1;
                end
            end
        end
    end

    assign at_boundary = (bit_cnt == '0);
    assign tx_next     = at_boundary ? (pending_valid ? pending_byte : 8'hFF)
                                     : {tx_shift[6:0], 1'b1};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_shift      <= 8'hFF;
            sd_mosi       <= 1'b1;
            pending_byte  <= 8'hFF;
            pending_valid <= 1'b0;
        end else begin
            if (fall) begin
                tx_shift <= tx_next;
                sd_mosi  <= tx_next[7];
            end
            // A capture on the boundary cycle wins over the consume of the old byte.
            if (load_enable) begin
                pending_byte  <= sel_byte;
                pending_valid <= 1'b1;
            end else if (fall && at_boundary) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule
